// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable countdown timer.
package timer_pkg;

    localparam int unsigned TIMER_STATE_W = 2;

    typedef enum logic [TIMER_STATE_W-1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Programmable down-counter with a load handshake and one-shot or auto-reload expiry.
// Status outputs are decoded straight from the state register; tick is a registered pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_value,
    input  logic         load_reload,
    input  logic         en,
    input  logic         abort,
    input  logic         done_ack,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         done,
    output logic         busy
);

    timer_state_t state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] period_q, period_d;
    logic         reload_q, reload_d;
    logic         tick_q, tick_d;

    // Next state, count and tick; abort outranks expiry, reload and acknowledge.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        reload_d = reload_q;
        tick_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    period_d = load_value;
                    reload_d = load_reload;
                    count_d  = load_value;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (en) begin
                    if (count_q != '0) begin
                        count_d = count_q - N'(1);
                    end else begin
                        tick_d = 1'b1;
                        if (reload_q) begin
                            count_d = period_q;
                        end else begin
                            state_d = EXPIRED;
                        end
                    end
                end
            end
            EXPIRED: begin
                count_d = '0;
                if (abort || done_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            reload_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == EXPIRED);
    assign count      = count_q;
    assign tick       = tick_q;

endmodule : countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counting timer.
- Software or an upstream FSM loads a period through a valid/ready handshake.
- The block counts down to zero while enabled. Each expiry produces a one-cycle tick.
- Two modes: one-shot (holds a done level until acknowledged) or auto-reload (periodic tick with period = load value + 1 cycles).
- Counterpart to the saturating up-counter: counts toward zero and saturates there, never wraps.

Parameters:
- N, 8, width of period register and count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- load_valid  input  1  period load request
- load_ready  output  1  high when a load can be accepted (state IDLE)
- load_value  input  N  period minus one; sampled on handshake
- load_reload  input  1  1 = auto-reload mode, 0 = one-shot; sampled on handshake
- en  input  1  count enable; 0 freezes count and state
- abort  input  1  cancel current operation, return to IDLE
- done_ack  input  1  acknowledge one-shot expiry
- count  output  N  current count value
- tick  output  1  registered one-cycle expiry pulse
- done  output  1  level, high while in EXPIRED
- busy  output  1  high in RUN

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE
  - count=0, period=0, reload=0
  - tick=0, done=0, busy=0
  - load_ready=1
- States: IDLE, RUN, EXPIRED. The state register is the only source of load_ready, busy and done, which are decoded from it (no extra latency).
- IDLE:
  - Handshake = load_valid & load_ready.
  - On handshake at edge e0: period<=load_value, reload<=load_reload, count<=load_value, state<=RUN.
  - abort and done_ack are ignored in IDLE.
- RUN with en=1:
  - If count>0: count<=count-1.
  - If count==0: tick<=1. Then:
    - reload=1: count<=period, stay RUN.
    - reload=0: state<=EXPIRED, count stays 0.
- RUN with en=0: count, state and period hold; tick<=0.
- Timing with en held high:
  - First tick is registered at edge e(V+1) after the handshake edge e0 (V = load_value).
  - Auto-reload ticks repeat every V+1 cycles.
- EXPIRED:
  - done=1, count=0.
  - done_ack=1 -> IDLE at next edge.
  - en has no effect.
- tick: deasserts the cycle after it asserts (exactly one cycle wide). Never asserts on the same edge as an abort.
- abort in RUN or EXPIRED: next edge state<=IDLE, count<=0, tick<=0. abort has priority over expiry, reload and done_ack.
- Loads outside IDLE are not accepted (load_ready=0). period and reload are unchanged.
- load_value=0:
  - One-shot: tick at e1, then EXPIRED.
  - Auto-reload: tick every cycle while en=1.
- load_value=2^N-1: 2^N-cycle period. No overflow: arithmetic is only decrement-when-nonzero, so count never wraps below 0.
- rst asserted mid-RUN or mid-EXPIRED: immediate return to reset values; a pending tick is lost.

Decomposition:
- Package timer_pkg:
  - state typedef timer_state_t, 2 bits: IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10.
  - Constant TIMER_STATE_W=2.
- Single module; no sub-module needed. Next-state/next-count logic is one combinational block, registers are one async-reset sequential block.

Test Plan:
- Reset: run with load_value=5, assert rst at count=3 -> same cycle count=0, busy=0, load_ready=1, tick=0, done=0.
- One-shot: load 3, reload=0, en=1:
  - count goes 3,2,1,0; tick=1 exactly at e4.
  - done=1 and load_ready=0 held 10 cycles; done_ack -> IDLE next edge, load_ready=1.
- Auto-reload: load 2, reload=1, en=1 for 12 cycles -> count goes 2,1,0,2,1,0...; tick at e3, e6, e9, e12; done never 1.
- Pause: load 4, drop en for 5 cycles when count=2 -> count holds 2, tick delayed by exactly 5 cycles (e10 instead of e5).
- Abort/load collisions:
  - abort with en=1 in the cycle where count==0 -> no tick, IDLE next edge, count=0.
  - load_valid asserted during RUN with value 7 -> not accepted; period unchanged.
- Boundaries:
  - load 0 one-shot -> tick at e1, then EXPIRED.
  - load 255 (N=8) auto-reload -> ticks 256 cycles apart; count never exceeds 255 or wraps.
